// File: rtl/tetris_input_pkg.sv
// Shared definitions for the Tetris push-button input path: repeat FSM
// encodings and default timing constants for a 27 MHz system clock.
package tetris_input_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    // 10 ms debounce, 160 ms delayed auto-shift, 50 ms auto-repeat at 27 MHz
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 270_000;
    localparam int unsigned DEF_DAS_CYCLES      = 4_320_000;
    localparam int unsigned DEF_ARR_CYCLES      = 1_350_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-flop synchronizer, debounce counter and the
// DAS/ARR repeat FSM that produces the fire pulse train.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | button released, waiting for a debounced press
//   ST_DELAY  | press fired, counting DAS cycles to the first repeat
//   ST_REPEAT | auto-repeating, one fire every ARR cycles while held
module button_channel
    import tetris_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned DAS_CYCLES      = DEF_DAS_CYCLES,
    parameter int unsigned ARR_CYCLES      = DEF_ARR_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic held,
    output logic press,
    output logic rel,
    output logic fire
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RW = $clog2(max_u(DAS_CYCLES, ARR_CYCLES) + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DAS_LAST = RW'(DAS_CYCLES - 1);
    localparam logic [RW-1:0] ARR_LAST = RW'(ARR_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          s;
    logic [DW-1:0] dcnt;
    logic          flip;
    logic          press_nxt;
    logic          rel_nxt;

    rep_state_t    state;
    rep_state_t    state_nxt;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_nxt;
    logic          fire_nxt;

    // Two-flop synchronizer; resets to released so a button held through
    // reset is seen as a fresh press once reset lifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    assign s         = ~sync2;
    assign flip      = (s != held) && (dcnt == DEB_LAST);
    assign press_nxt = flip & s;
    assign rel_nxt   = flip & ~s;

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
    // samples that disagree with the held level; press/release mark the change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt  <= '0;
            held  <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= press_nxt;
            rel   <= rel_nxt;
            if (s == held) begin
                dcnt <= '0;
            end else if (flip) begin
                held <= s;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    // Repeat FSM register; fire is registered so it lines up with press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            rcnt  <= '0;
            fire  <= 1'b0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
            fire  <= fire_nxt;
        end
    end

    // Repeat FSM next-state; a release wins over a coinciding terminal count.
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        fire_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (press_nxt) begin
                    state_nxt = ST_DELAY;
                    rcnt_nxt  = '0;
                    fire_nxt  = 1'b1;
                end
            end
            ST_DELAY: begin
                if (rel_nxt) begin
                    state_nxt = ST_IDLE;
                    rcnt_nxt  = '0;
                end else if (rcnt == DAS_LAST) begin
                    state_nxt = ST_REPEAT;
                    rcnt_nxt  = '0;
                    fire_nxt  = 1'b1;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (rel_nxt) begin
                    state_nxt = ST_IDLE;
                    rcnt_nxt  = '0;
                end else if (rcnt == ARR_LAST) begin
                    rcnt_nxt = '0;
                    fire_nxt = 1'b1;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                rcnt_nxt  = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_conditioner.sv
// Button input stage: N_BTN independent conditioned channels plus the
// active-low LED bank mirroring each debounced held level.
module button_conditioner
    import tetris_input_pkg::*;
#(
    parameter int unsigned N_BTN           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned DAS_CYCLES      = DEF_DAS_CYCLES,
    parameter int unsigned ARR_CYCLES      = DEF_ARR_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] held,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] rel,
    output logic [N_BTN-1:0] fire,
    output logic [N_BTN-1:0] led_n
);

    for (genvar g = 0; g < int'(N_BTN); g++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DAS_CYCLES      (DAS_CYCLES),
            .ARR_CYCLES      (ARR_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_n (btn_n[g]),
            .held  (held[g]),
            .press (press[g]),
            .rel   (rel[g]),
            .fire  (fire[g])
        );
    end

    // LED lit (low) while the button is held
    assign led_n = ~held;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short timing parameters.
module tb_button_conditioner;

    localparam int N   = 2;
    localparam int D   = 4;
    localparam int DAS = 10;
    localparam int ARR = 3;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] btn_n = '1;
    logic [N-1:0] held;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] fire;
    logic [N-1:0] led_n;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D),
        .DAS_CYCLES      (DAS),
        .ARR_CYCLES      (ARR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_n),
        .held  (held),
        .press (press),
        .rel   (rel),
        .fire  (fire),
        .led_n (led_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw button seen two edges late, level accepted once the
    // last D samples all disagree with it, fire times from arithmetic on t0.
    bit m_b1   [N];
    bit m_b2   [N];
    bit m_win  [N][D];
    bit m_held [N];
    bit e_press[N];
    bit e_rel  [N];
    bit e_fire [N];
    int m_t0   [N];
    int cyc;

    int press_cnt[N];
    int rel_cnt  [N];
    int fire_cnt [N];
    int press_cyc[N];

    task automatic clr_cnt();
        for (int c = 0; c < N; c++) begin
            press_cnt[c] = 0;
            rel_cnt[c]   = 0;
            fire_cnt[c]  = 0;
            press_cyc[c] = -1;
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int c = 0; c < N; c++) begin
            m_b1[c] = 1'b1;
            m_b2[c] = 1'b1;
            for (int j = 0; j < D; j++) m_win[c][j] = 1'b0;
            m_held[c]  = 1'b0;
            e_press[c] = 1'b0;
            e_rel[c]   = 1'b0;
            e_fire[c]  = 1'b0;
            m_t0[c]    = 0;
        end
    endtask

    task automatic model_edge();
        bit s_in;
        bit all_diff;
        bit nh;
        int dt;
        cyc++;
        for (int c = 0; c < N; c++) begin
            s_in    = !m_b2[c];
            m_b2[c] = m_b1[c];
            m_b1[c] = btn_n[c];
            for (int j = D - 1; j > 0; j--) m_win[c][j] = m_win[c][j-1];
            m_win[c][0] = s_in;
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) if (m_win[c][j] == m_held[c]) all_diff = 1'b0;
            nh = all_diff ? !m_held[c] : m_held[c];
            e_press[c] = nh && !m_held[c];
            e_rel[c]   = !nh && m_held[c];
            if (e_press[c]) m_t0[c] = cyc;
            dt = cyc - m_t0[c];
            e_fire[c] = nh && (e_press[c] || (dt >= DAS && ((dt - DAS) % ARR) == 0));
            m_held[c] = nh;
        end
    endtask

    task automatic check_outputs();
        for (int c = 0; c < N; c++) begin
            chk($sformatf("held%0d", c),  held[c],  m_held[c]);
            chk($sformatf("press%0d", c), press[c], e_press[c]);
            chk($sformatf("rel%0d", c),   rel[c],   e_rel[c]);
            chk($sformatf("fire%0d", c),  fire[c],  e_fire[c]);
            chk($sformatf("led_n%0d", c), led_n[c], !m_held[c]);
            if (press[c]) begin
                press_cnt[c]++;
                if (press_cyc[c] < 0) press_cyc[c] = cyc;
            end
            if (rel[c])  rel_cnt[c]++;
            if (fire[c]) fire_cnt[c]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Called at a negedge: assert reset mid-cycle, check the asynchronous
    // clear, hold for a few edges, release at a negedge.
    task automatic mid_reset(input int hold_edges);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_held",  held,  0);
        chk("rst_press", press, 0);
        chk("rst_rel",   rel,   0);
        chk("rst_fire",  fire,  0);
        chk("rst_led_n", led_n, 2'b11);
        model_reset();
        repeat (hold_edges) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_held", held, 0);
        chk("rst_hold_fire", fire, 0);
        rst_n = 1'b1;
    endtask

    int base;

    initial begin
        model_reset();
        clr_cnt();

        // power-on reset with buttons released, then 20 quiet cycles
        @(negedge clk);
        mid_reset(3);
        run(20);
        chk("quiet_press", press_cnt[0] + press_cnt[1], 0);
        chk("quiet_fire",  fire_cnt[0] + fire_cnt[1], 0);

        // clean press held 30 cycles then released
        clr_cnt();
        base = cyc;
        btn_n[0] = 1'b0;
        run(30);
        btn_n[0] = 1'b1;
        run(15);
        chk("clean_press_lat", press_cyc[0] - base, D + 2);
        chk("clean_press_cnt", press_cnt[0], 1);
        chk("clean_rel_cnt",   rel_cnt[0], 1);
        chk("clean_fire_cnt",  fire_cnt[0], 8);
        chk("clean_ch1_quiet", fire_cnt[1] + press_cnt[1], 0);

        // bounce: 3 low, 1 high, 3 low -> rejected
        clr_cnt();
        btn_n[0] = 1'b0; run(3);
        btn_n[0] = 1'b1; run(1);
        btn_n[0] = 1'b0; run(3);
        btn_n[0] = 1'b1; run(12);
        chk("bounce_press_cnt", press_cnt[0], 0);
        chk("bounce_fire_cnt",  fire_cnt[0], 0);
        // exactly D low samples -> accepted
        btn_n[0] = 1'b0; run(D);
        btn_n[0] = 1'b1; run(14);
        chk("bounce4_press_cnt", press_cnt[0], 1);
        chk("bounce4_fire_cnt",  fire_cnt[0], 1);

        // release during DELAY
        clr_cnt();
        btn_n[0] = 1'b0; run(8);
        btn_n[0] = 1'b1; run(25);
        chk("delay_rel_fire_cnt", fire_cnt[0], 1);
        chk("delay_rel_rel_cnt",  rel_cnt[0], 1);

        // reset asserted in REPEAT with the button still held
        btn_n[0] = 1'b0;
        run(25);
        chk("pre_rst_held", held[0], 1'b1);
        mid_reset(2);
        clr_cnt();
        run(20);
        chk("rst_repress_lat", press_cyc[0], D + 2);
        chk("rst_repress_cnt", press_cnt[0], 1);
        chk("rst_refire_cnt",  fire_cnt[0], 3);
        btn_n[0] = 1'b1;
        run(12);

        // two channels pressed two cycles apart
        clr_cnt();
        btn_n[0] = 1'b0; run(2);
        btn_n[1] = 1'b0; run(30);
        btn_n = 2'b11;   run(15);
        chk("dual_press_offset", press_cyc[1] - press_cyc[0], 2);
        chk("dual_press_cnt",    press_cnt[0] + press_cnt[1], 2);

        // randomized level activity with occasional resets
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(5) == 0) btn_n[c] = ~btn_n[c];
            if ($urandom_range(799) == 0) mid_reset($urandom_range(1, 3));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
